// File: rtl/sys_ctrl_pkg.sv
// Shared constants and state encoding for the system command controller.
// The burst states are only reachable when SYS_CTRL_BURST_EN is defined.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
    localparam logic [7:0] CMD_BURST   = 8'hEE;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_WAIT,
        S_ALU_A,
        S_ALU_B,
        S_ALU_FUN,
        S_ALU_WAIT,
        S_PUSH,
        S_BST_ADDR,
        S_BST_CNT,
        S_BST_DATA
    } state_e;

endpackage

// File: rtl/sys_ctrl_tx_ser.sv
// Response serializer: shifts a loaded result out one frame per non-full
// cycle, least significant frame first, into the TX FIFO.
module sys_ctrl_tx_ser #(
    parameter int unsigned Data_width    = 8,
    parameter int unsigned ALU_OUT_width = 16,
    parameter int unsigned CNT_W         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [ALU_OUT_width-1:0] load_data,
    input  logic [CNT_W-1:0]         load_cnt,
    input  logic                     fifo_full,
    output logic [Data_width-1:0]    tx_p_data,
    output logic                     tx_d_vld,
    output logic                     last
);

    logic [ALU_OUT_width-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [Data_width-1:0]    tx_data_q, tx_data_d;
    logic                     tx_vld_q, tx_vld_d;

    always_comb begin
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = 1'b0;
        if (load) begin
            shreg_d = load_data;
            cnt_d   = load_cnt;
        end else if ((cnt_q != '0) && !fifo_full) begin
            tx_vld_d  = 1'b1;
            tx_data_d = shreg_q[Data_width-1:0];
            shreg_d   = shreg_q >> Data_width;
            cnt_d     = cnt_q - CNT_W'(1);
        end
    end

    // Lets the FSM leave PUSH on the same cycle the final frame is committed.
    assign last = !load && (cnt_q == CNT_W'(1)) && !fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
        end
    end

    assign tx_p_data = tx_data_q;
    assign tx_d_vld  = tx_vld_q;

endmodule

// File: rtl/sys_ctrl_gen.sv
// Byte-stream command controller for register file, ALU and TX FIFO.
// Define SYS_CTRL_BURST_EN to build the 0xEE burst-write command.
module sys_ctrl_gen
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned Data_width    = 8,
    parameter int unsigned Address_width = 4,
    parameter int unsigned ALU_OUT_width = 16,
    parameter int unsigned RESP_BYTES    = ALU_OUT_width / Data_width
) (
    input  logic                     Ref_clk,
    input  logic                     RST,
    input  logic [Data_width-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [Address_width-1:0] Address,
    output logic [Data_width-1:0]    WrData,
    input  logic [Data_width-1:0]    RdData,
    input  logic                     RdData_Valid,
    output logic [3:0]               ALU_FUN,
    output logic                     ALU_EN,
    input  logic [ALU_OUT_width-1:0] ALU_OUT,
    input  logic                     OUT_Valid,
    output logic                     CLK_GATE_EN,
    output logic [Data_width-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     FIFO_FULL,
    output logic                     cmd_error
);

    localparam int unsigned CNT_W = $clog2(RESP_BYTES) + 1;

    state_e                   state_q, state_d;
    logic [Address_width-1:0] address_q, address_d;
    logic [Data_width-1:0]    wr_data_q, wr_data_d;
    logic                     wr_en_q, wr_en_d;
    logic                     rd_en_q, rd_en_d;
    logic [3:0]               alu_fun_q, alu_fun_d;
    logic                     alu_en_q, alu_en_d;
    logic                     clk_gate_q, clk_gate_d;
    logic                     cmd_err_q, cmd_err_d;

    logic                     ser_load, ser_last;
    logic [ALU_OUT_width-1:0] ser_data;
    logic [CNT_W-1:0]         ser_cnt;

`ifdef SYS_CTRL_BURST_EN
    logic [Address_width-1:0] bst_ptr_q, bst_ptr_d;
    logic [Data_width-1:0]    bst_cnt_q, bst_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_fun_d = alu_fun_q;
        alu_en_d  = 1'b0;
        cmd_err_d = 1'b0;
        ser_load  = 1'b0;
        ser_data  = '0;
        ser_cnt   = '0;
`ifdef SYS_CTRL_BURST_EN
        bst_ptr_d = bst_ptr_q;
        bst_cnt_d = bst_cnt_q;
`endif
        case (state_q)
            S_IDLE: if (RX_D_VLD) begin
                case (RX_P_DATA)
                    Data_width'(CMD_WR):      state_d = S_WR_ADDR;
                    Data_width'(CMD_RD):      state_d = S_RD_ADDR;
                    Data_width'(CMD_ALU_OP):  state_d = S_ALU_A;
                    Data_width'(CMD_ALU_NOP): state_d = S_ALU_FUN;
`ifdef SYS_CTRL_BURST_EN
                    Data_width'(CMD_BURST):   state_d = S_BST_ADDR;
`endif
                    default:                  cmd_err_d = 1'b1;
                endcase
            end
            S_WR_ADDR: if (RX_D_VLD) begin
                address_d = RX_P_DATA[Address_width-1:0];
                state_d   = S_WR_DATA;
            end
            S_WR_DATA: if (RX_D_VLD) begin
                wr_en_d   = 1'b1;
                wr_data_d = RX_P_DATA;
                state_d   = S_IDLE;
            end
            S_RD_ADDR: if (RX_D_VLD) begin
                address_d = RX_P_DATA[Address_width-1:0];
                rd_en_d   = 1'b1;
                state_d   = S_RD_WAIT;
            end
            S_RD_WAIT: if (RdData_Valid) begin
                ser_load = 1'b1;
                ser_data = ALU_OUT_width'(RdData);
                ser_cnt  = CNT_W'(1);
                state_d  = S_PUSH;
            end
            S_ALU_A: if (RX_D_VLD) begin
                address_d = Address_width'(OPA_ADDR);
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = S_ALU_B;
            end
            S_ALU_B: if (RX_D_VLD) begin
                address_d = Address_width'(OPB_ADDR);
                wr_data_d = RX_P_DATA;
                wr_en_d   = 1'b1;
                state_d   = S_ALU_FUN;
            end
            S_ALU_FUN: if (RX_D_VLD) begin
                alu_fun_d = RX_P_DATA[3:0];
                alu_en_d  = 1'b1;
                state_d   = S_ALU_WAIT;
            end
            S_ALU_WAIT: if (OUT_Valid) begin
                ser_load = 1'b1;
                ser_data = ALU_OUT;
                ser_cnt  = CNT_W'(RESP_BYTES);
                state_d  = S_PUSH;
            end
            S_PUSH: if (ser_last) state_d = S_IDLE;
`ifdef SYS_CTRL_BURST_EN
            S_BST_ADDR: if (RX_D_VLD) begin
                bst_ptr_d = RX_P_DATA[Address_width-1:0];
                state_d   = S_BST_CNT;
            end
            S_BST_CNT: if (RX_D_VLD) begin
                bst_cnt_d = RX_P_DATA;
                state_d   = (RX_P_DATA == '0) ? S_IDLE : S_BST_DATA;
            end
            // Pointer advances separately so the write uses the pre-increment address.
            S_BST_DATA: if (RX_D_VLD) begin
                wr_en_d   = 1'b1;
                wr_data_d = RX_P_DATA;
                address_d = bst_ptr_q;
                bst_ptr_d = bst_ptr_q + Address_width'(1);
                bst_cnt_d = bst_cnt_q - Data_width'(1);
                if (bst_cnt_q == Data_width'(1)) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        clk_gate_d = (state_d == S_ALU_FUN) || (state_d == S_ALU_WAIT);
    end

    always_ff @(posedge Ref_clk or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            address_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            alu_fun_q  <= '0;
            alu_en_q   <= 1'b0;
            clk_gate_q <= 1'b0;
            cmd_err_q  <= 1'b0;
`ifdef SYS_CTRL_BURST_EN
            bst_ptr_q  <= '0;
            bst_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            alu_fun_q  <= alu_fun_d;
            alu_en_q   <= alu_en_d;
            clk_gate_q <= clk_gate_d;
            cmd_err_q  <= cmd_err_d;
`ifdef SYS_CTRL_BURST_EN
            bst_ptr_q  <= bst_ptr_d;
            bst_cnt_q  <= bst_cnt_d;
`endif
        end
    end

    sys_ctrl_tx_ser #(
        .Data_width   (Data_width),
        .ALU_OUT_width(ALU_OUT_width),
        .CNT_W        (CNT_W)
    ) u_tx_ser (
        .clk      (Ref_clk),
        .rst_n    (RST),
        .load     (ser_load),
        .load_data(ser_data),
        .load_cnt (ser_cnt),
        .fifo_full(FIFO_FULL),
        .tx_p_data(TX_P_DATA),
        .tx_d_vld (TX_D_VLD),
        .last     (ser_last)
    );

    assign WrEn        = wr_en_q;
    assign RdEn        = rd_en_q;
    assign Address     = address_q;
    assign WrData      = wr_data_q;
    assign ALU_FUN     = alu_fun_q;
    assign ALU_EN      = alu_en_q;
    assign CLK_GATE_EN = clk_gate_q;
    assign cmd_error   = cmd_err_q;

endmodule

// File: doc/sys_ctrl_gen.md
Name: sys_ctrl_gen

Overview:
- Parametrised command controller between UART RX/TX and the register file and ALU in the system top.
- Parses byte-stream commands 0xAA, 0xBB, 0xCC and 0xDD, and (optionally) a new burst-write command 0xEE.
- Drives register-file and ALU strobes and gates the ALU clock.
- Pushes response bytes into the TX async FIFO with back-pressure. ALU results wider than one frame are sent as multiple bytes.

Parameters:
- Data_width, 8, width of one RX/TX frame and of register-file data.
- Address_width, 4, register-file address width; address bytes use their Address_width LSBs.
- ALU_OUT_width, 16, ALU result width; must be a multiple of Data_width.
- RESP_BYTES, ALU_OUT_width/Data_width, number of frames pushed per ALU result, least significant first.

Ports:
- Ref_clk  in  1  system reference clock.
- RST  in  1  asynchronous active-low reset.
- RX_P_DATA  in  Data_width  parallel byte from the RX data synchroniser.
- RX_D_VLD  in  1  single-cycle valid pulse for RX_P_DATA.
- WrEn  out  1  register-file write strobe, one cycle.
- RdEn  out  1  register-file read strobe, one cycle.
- Address  out  Address_width  register-file address.
- WrData  out  Data_width  register-file write data.
- RdData  in  Data_width  register-file read data.
- RdData_Valid  in  1  read data valid pulse.
- ALU_FUN  out  4  ALU function code.
- ALU_EN  out  1  ALU enable, one cycle.
- ALU_OUT  in  ALU_OUT_width  ALU result.
- OUT_Valid  in  1  ALU result valid pulse.
- CLK_GATE_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  Data_width  byte written to the TX FIFO.
- TX_D_VLD  out  1  FIFO write strobe.
- FIFO_FULL  in  1  TX FIFO full.
- cmd_error  out  1  one-cycle pulse on an unknown command byte.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all holding registers cleared. Reset asserted mid-command aborts the command with no further strobes.
- Registered outputs; every strobe appears one cycle after the RX_D_VLD or valid input that causes it.
- Bytes are consumed only on RX_D_VLD. Bytes are never dropped while the FSM waits on RdData_Valid, OUT_Valid or FIFO_FULL: RX_D_VLD in those states is ignored and must not occur per protocol.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, PUSH, BST_ADDR, BST_CNT, BST_DATA.
- IDLE:
  - 0xAA -> WR_ADDR.
  - 0xBB -> RD_ADDR.
  - 0xCC -> ALU_A.
  - 0xDD -> ALU_FUN.
  - 0xEE -> BST_ADDR (when the optional feature is enabled).
  - Any other byte -> pulse cmd_error, stay in IDLE.
- 0xAA (write): latch address in WR_ADDR. In WR_DATA, pulse WrEn with the latched Address and WrData = byte, then -> IDLE.
- 0xBB (read): in RD_ADDR, pulse RdEn -> RD_WAIT. On RdData_Valid, load one response byte -> PUSH.
- 0xCC (ALU with operands):
  - ALU_A writes the operand to address 0 (WrEn pulse).
  - ALU_B writes the operand to address 1.
  - ALU_FUN: ALU_FUN = byte[3:0], ALU_EN pulse -> ALU_WAIT.
- 0xDD (ALU, no operands): goes straight to ALU_FUN and reuses the stored operands.
- CLK_GATE_EN: high from entry to ALU_FUN until the cycle after OUT_Valid.
- ALU_WAIT: on OUT_Valid, latch ALU_OUT and load RESP_BYTES frames -> PUSH.
- PUSH:
  - Each cycle with FIFO_FULL=0, pulse TX_D_VLD with the next frame, least significant first.
  - With FIFO_FULL=1, hold and retry; no frame is lost or duplicated.
  - After the last frame -> IDLE.
- Byte counter: width clog2(RESP_BYTES)+1; it does not wrap.
- Simultaneous events: an RX_D_VLD arriving in the same cycle as the final PUSH write is treated as a new command byte in IDLE on the next cycle only if it is still valid then. Inputs are pulses, so the byte is lost; the spec forbids the sender from doing this.

Optional Feature:
- Macro: SYS_CTRL_BURST_EN.
- Defined: 0xEE is a burst write. BST_ADDR latches the start address; BST_CNT latches N (0–255).
  - N=0 -> IDLE with no write.
  - In BST_DATA, each byte pulses WrEn, and the address increments modulo 2^Address_width (15 wraps to 0). Return to IDLE after N bytes.
- Undefined: no burst states are built, and 0xEE produces cmd_error like any unknown byte.

Decomposition:
- Package sys_ctrl_pkg holds:
  - Command constants CMD_WR=0xAA, CMD_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD, CMD_BURST=0xEE.
  - The state enum.
  - Operand addresses OPA_ADDR=0 and OPB_ADDR=1.
- One sub-module, sys_ctrl_tx_ser: a response serializer holding the RESP_BYTES shift register, byte counter and FIFO_FULL handshake.

Test Plan:
- AA,05,55 then BB,05 -> WrEn at Address 5 with data 0x55; the FIFO receives a single 0x55.
- CC,0A,19,00 with ALU_OUT=0x0023 -> regfile writes addr0=0x0A and addr1=0x19; FIFO receives 0x23 then 0x00; CLK_GATE_EN drops the cycle after OUT_Valid.
- DD,02 with ALU_OUT=0x01F8 and FIFO_FULL held high for 5 cycles at the first push -> no TX_D_VLD while full, then exactly 0xF8 then 0x01.
- Byte 0x3C in IDLE -> cmd_error pulses once, no other strobes; a following AA,01,7E performs the write normally.
- Burst EE,0E,03,11,22,33 (macro defined) -> writes 0x11@14, 0x22@15, 0x33@0; EE,04,00 -> no write. With the macro undefined, EE -> cmd_error.
- RST low during ALU_WAIT -> all outputs 0 immediately; a late OUT_Valid after release produces no FIFO write.
